pic_fetch: RTL and testbench
============================

# pic_fetch

Instruction-fetch stage for the structural 12-bit PIC core. It owns the 9-bit program counter and drives the combinational program ROM address. It registers the returned word into the instruction register and resolves control flow locally: GOTO, CALL and RETLW are decoded here, and skip requests come back from the execute stage. Downstream, the decode/execute datapath consumes `ir`/`ir_valid`.

## Interface
Parameters:
- `RESET_VECTOR`, default 9'h000: PC value loaded on reset.
- `NOP_WORD`, default 12'h000: word inserted into `ir` on flush, reset and skip.

Ports:
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `reset`, input, 1: synchronous, active-high.
- `rom_addr`, output, 9: equals `pc` (combinational from the PC register).
- `rom_data`, input, 12: ROM word for `rom_addr`, valid in the same cycle.
- `stall`, input, 1: freezes PC, IR and stack.
- `skip_req`, input, 1: execute stage requests that the next instruction be discarded (BTFSx/xFSZ taken).
- `ir`, output, 12: instruction currently in execute.
- `ir_valid`, output, 1: `ir` holds a fetched word, not an inserted NOP.
- `pc`, output, 9: current fetch address.
- `stk_err`, output, 1: sticky stack overflow/underflow flag (see Configuration).

## Operation
- Decode of `ir`, 12-bit PIC encoding:
  - GOTO = `101k_kkkk_kkkk`, target `ir[8:0]`.
  - CALL = `1001_kkkk_kkkk`, target `{1'b0, ir[7:0]}`.
  - RETLW = `1000_kkkk_kkkk`.
- Stack: 2 levels, `stk0` (top) and `stk1`, with depth counter `sp` in 0..2.
  - Push: `stk1 <= stk0; stk0 <= pc`.
  - Pop: `stk0 <= stk1`, returns the old `stk0`.
- Per-edge priority, highest first:
  1. `reset`: `pc <= RESET_VECTOR`, `ir <= NOP_WORD`, `ir_valid <= 0`, `sp <= 0`, `stk0 = stk1 <= 0`, `stk_err <= 0`.
  2. `stall`: all state holds.
  3. `ir` is GOTO and `ir_valid`: `pc <= target`, `ir <= NOP_WORD`, `ir_valid <= 0`. The in-flight fetch is discarded.
  4. `ir` is CALL and `ir_valid`: push `pc` (already the return address), `pc <= target`, flush as above.
  5. `ir` is RETLW and `ir_valid`: `pc <= pop`, flush as above. The execute stage loads W from `ir[7:0]`; that is not handled here.
  6. `skip_req`: `ir <= NOP_WORD`, `ir_valid <= 0`, `pc <= pc+1`.
  7. Otherwise: `ir <= rom_data`, `ir_valid <= 1`, `pc <= pc+1`.
- `skip_req` coinciding with a decoded GOTO/CALL/RETLW is ignored; the control-flow action wins.
- `pc+1` is 9-bit modulo: 9'h1FF wraps to 9'h000.
- Push at `sp==2`: `stk1` (oldest entry) is lost and `sp` stays 2.
- Pop at `sp==0`: returns `stk0` unchanged (hardware duplicate behaviour) and `sp` stays 0.

## Timing
- ROM path is combinational. Fetch latency is 1 cycle: the word at `rom_addr` in cycle N appears on `ir` in cycle N+1.
- Taken GOTO/CALL/RETLW and `skip_req` each cost exactly one bubble cycle (`ir_valid=0`).
- Reset values: `rom_addr=pc=RESET_VECTOR`, `ir=NOP_WORD`, `ir_valid=0`, `stk_err=0`.
- First valid instruction appears on `ir` one edge after `reset` deasserts.
- `reset` asserted mid-operation, including during a flush or with `stall` high, overrides everything on that edge.
- `stall` holds `ir_valid`. A flush pending in `ir` takes effect on the first unstalled edge.

## Configuration
- `PIC_FETCH_STACK_CHECK_EN` defined:
  - `stk_err` sets on push at `sp==2` or pop at `sp==0`.
  - Clears only on `reset`.
- Undefined:
  - `stk_err` is tied to 0 and the check logic is absent.
  - Stack overflow/underflow behaviour is otherwise identical.

## Test plan
- Reset then free-run over sequential MOVLW words:
  - `rom_addr` steps 0,1,2,... one per cycle.
  - `ir` in cycle k equals `rom[k-1]`; `ir_valid=1` from the first post-reset edge onward.
- `rom[31]=12'hA25` (GOTO 0x25):
  - Cycle after it is in `ir`: `ir=000`, `ir_valid=0`.
  - Next `rom_addr=0x025`; `rom[32]` never reaches `ir` as valid.
- `rom[5]=CALL 0x12`, `rom[0x14]=RETLW 0x07`:
  - Stack top = 6, `rom_addr` goes to 0x012, then 0x013, 0x014.
  - After the RETLW bubble, `rom_addr=6`; `sp` returns to 0.
- `skip_req=1` for one cycle while `ir` holds a non-branch word at address 9:
  - Word from address 10 is replaced by NOP (`ir_valid=0`); fetch continues at 11.
- Three nested CALLs then three RETLWs, with the macro defined:
  - `stk_err=1` after the 3rd CALL and stays 1.
  - First return address lost; third RETLW returns the duplicated `stk0`.
  - Without the macro: same PC trace, `stk_err=0`.
- Edge cases:
  - PC at 0x1FF with sequential word: next `rom_addr=0x000`.
  - `stall` held 3 cycles: `pc`, `ir`, `ir_valid` unchanged.
  - `reset` pulsed during a GOTO bubble: `pc=0`, `ir=000`, `ir_valid=0`.

Source files
------------

// File: rtl/pic_fetch.sv
// Fetch stage for the 12-bit PIC core: PC, instruction register, 2-level call stack.
// Define PIC_FETCH_STACK_CHECK_EN to build the sticky stack overflow/underflow flag.
module pic_fetch #(
    parameter logic [8:0]  RESET_VECTOR = 9'h000,
    parameter logic [11:0] NOP_WORD     = 12'h000
) (
    input  logic        clk,
    input  logic        reset,
    output logic [8:0]  rom_addr,
    input  logic [11:0] rom_data,
    input  logic        stall,
    input  logic        skip_req,
    output logic [11:0] ir,
    output logic        ir_valid,
    output logic [8:0]  pc,
    output logic        stk_err
);

    logic [8:0]  pc_q, pc_d;
    logic [11:0] ir_q, ir_d;
    logic        irv_q, irv_d;
    logic [8:0]  stk0_q, stk0_d;
    logic [8:0]  stk1_q, stk1_d;
    logic [8:0]  pc_inc;
    logic        is_goto, is_call, is_retlw;
    logic        do_push, do_pop;

    assign pc_inc   = pc_q + 9'd1;
    assign is_goto  = irv_q && (ir_q[11:9] == 3'b101);
    assign is_call  = irv_q && (ir_q[11:8] == 4'b1001);
    assign is_retlw = irv_q && (ir_q[11:8] == 4'b1000);
    assign do_push  = !stall && is_call;
    assign do_pop   = !stall && is_retlw;

    always_comb begin
        pc_d   = pc_q;
        ir_d   = ir_q;
        irv_d  = irv_q;
        stk0_d = stk0_q;
        stk1_d = stk1_q;
        if (!stall) begin
            if (is_goto) begin
                pc_d  = ir_q[8:0];
                ir_d  = NOP_WORD;
                irv_d = 1'b0;
            end else if (is_call) begin
                // pc already points past the CALL, so it is the return address
                stk1_d = stk0_q;
                stk0_d = pc_q;
                pc_d   = {1'b0, ir_q[7:0]};
                ir_d   = NOP_WORD;
                irv_d  = 1'b0;
            end else if (is_retlw) begin
                // stk1 keeps its value, so popping an empty stack duplicates it
                pc_d   = stk0_q;
                stk0_d = stk1_q;
                ir_d   = NOP_WORD;
                irv_d  = 1'b0;
            end else if (skip_req) begin
                pc_d  = pc_inc;
                ir_d  = NOP_WORD;
                irv_d = 1'b0;
            end else begin
                pc_d  = pc_inc;
                ir_d  = rom_data;
                irv_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q   <= RESET_VECTOR;
            ir_q   <= NOP_WORD;
            irv_q  <= 1'b0;
            stk0_q <= 9'h000;
            stk1_q <= 9'h000;
        end else begin
            pc_q   <= pc_d;
            ir_q   <= ir_d;
            irv_q  <= irv_d;
            stk0_q <= stk0_d;
            stk1_q <= stk1_d;
        end
    end

`ifdef PIC_FETCH_STACK_CHECK_EN
    // Depth counter only feeds the error flag; stack data movement ignores it.
    logic [1:0] sp_q, sp_d;
    logic       err_q, err_d;

    always_comb begin
        sp_d  = sp_q;
        err_d = err_q;
        if (do_push) begin
            if (sp_q == 2'd2) err_d = 1'b1;
            else              sp_d  = sp_q + 2'd1;
        end else if (do_pop) begin
            if (sp_q == 2'd0) err_d = 1'b1;
            else              sp_d  = sp_q - 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sp_q  <= 2'd0;
            err_q <= 1'b0;
        end else begin
            sp_q  <= sp_d;
            err_q <= err_d;
        end
    end

    assign stk_err = err_q;
`else
    logic unused_chk;
    assign unused_chk = do_push ^ do_pop;
    assign stk_err    = 1'b0;
`endif

    assign rom_addr = pc_q;
    assign pc       = pc_q;
    assign ir       = ir_q;
    assign ir_valid = irv_q;

endmodule

// File: tb/tb_pic_fetch.sv
// Directed bench for pic_fetch: sequential fetch, GOTO/CALL/RETLW, skip, stack limits, wrap, stall, reset.
module tb_pic_fetch;

    logic        clk = 1'b0;
    logic        reset;
    logic [8:0]  rom_addr;
    logic [11:0] rom_data;
    logic        stall;
    logic        skip_req;
    logic [11:0] ir;
    logic        ir_valid;
    logic [8:0]  pc;
    logic        stk_err;

    logic [11:0] rom [512];
    int n_vec = 0;
    int n_err = 0;

`ifdef PIC_FETCH_STACK_CHECK_EN
    localparam logic EXP_ERR = 1'b1;
`else
    localparam logic EXP_ERR = 1'b0;
`endif

    always #5 clk = ~clk;

    assign rom_data = rom[rom_addr];

    pic_fetch dut (
        .clk      (clk),
        .reset    (reset),
        .rom_addr (rom_addr),
        .rom_data (rom_data),
        .stall    (stall),
        .skip_req (skip_req),
        .ir       (ir),
        .ir_valid (ir_valid),
        .pc       (pc),
        .stk_err  (stk_err)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Default image: MOVLW k with k = low address byte
    task automatic rom_fill();
        for (int i = 0; i < 512; i++) begin
            logic [8:0] a;
            a = i[8:0];
            rom[i] = {4'hC, a[7:0]};
        end
    endtask

    task automatic do_reset();
        reset = 1'b1; stall = 1'b0; skip_req = 1'b0;
        steps(2);
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; skip_req = 1'b0;
        rom_fill();

        // reset state and sequential fetch
        do_reset();
        chk("rst_pc", pc, 9'h000);
        chk("rst_addr", rom_addr, 9'h000);
        chk("rst_ir", ir, 12'h000);
        chk("rst_irv", ir_valid, 1'b0);
        chk("rst_err", stk_err, 1'b0);
        for (int k = 1; k <= 5; k++) begin
            step();
            chk("seq_addr", rom_addr, k);
            chk("seq_ir", ir, {4'hC, 8'(k - 1)});
            chk("seq_irv", ir_valid, 1'b1);
        end

        // GOTO 0x25 at address 31
        rom_fill();
        rom[31] = 12'hA25;
        rom[32] = 12'h3AB;
        do_reset();
        steps(32);
        chk("goto_ir", ir, 12'hA25);
        step();
        chk("goto_bub_ir", ir, 12'h000);
        chk("goto_bub_irv", ir_valid, 1'b0);
        chk("goto_addr", rom_addr, 9'h025);
        step();
        chk("goto_tgt_ir", ir, 12'hC25);
        chk("goto_tgt_irv", ir_valid, 1'b1);
        chk("goto_tgt_pc", pc, 9'h026);

        // CALL 0x12 at 5, RETLW at 0x14
        rom_fill();
        rom[5]    = 12'h912;
        rom[9'h14] = 12'h807;
        do_reset();
        steps(6);
        chk("call_ir", ir, 12'h912);
        step();
        chk("call_addr", rom_addr, 9'h012);
        chk("call_irv", ir_valid, 1'b0);
        step();
        chk("call_a13", rom_addr, 9'h013);
        step();
        chk("call_a14", rom_addr, 9'h014);
        step();
        chk("ret_ir", ir, 12'h807);
        step();
        chk("ret_addr", rom_addr, 9'h006);
        chk("ret_irv", ir_valid, 1'b0);
        step();
        chk("ret_next_ir", ir, 12'hC06);

        // skip while address 9 is in ir
        rom_fill();
        do_reset();
        steps(10);
        chk("skip_pre_ir", ir, 12'hC09);
        skip_req = 1'b1;
        step();
        skip_req = 1'b0;
        chk("skip_ir", ir, 12'h000);
        chk("skip_irv", ir_valid, 1'b0);
        chk("skip_addr", rom_addr, 9'h00B);
        step();
        chk("skip_next_ir", ir, 12'hC0B);

        // three nested CALLs and three RETLWs
        rom_fill();
        rom[2]     = 12'h910;
        rom[9'h10] = 12'h920;
        rom[9'h20] = 12'h930;
        rom[9'h30] = 12'h801;
        rom[9'h21] = 12'h802;
        rom[9'h11] = 12'h803;
        do_reset();
        steps(4);
        chk("nest_c1", pc, 9'h010);
        steps(2);
        chk("nest_c2", pc, 9'h020);
        chk("nest_err0", stk_err, 1'b0);
        steps(2);
        chk("nest_c3", pc, 9'h030);
        chk("nest_err1", stk_err, EXP_ERR);
        steps(2);
        chk("nest_r1", pc, 9'h021);
        steps(2);
        chk("nest_r2", pc, 9'h011);
        steps(2);
        chk("nest_r3_dup", pc, 9'h011);
        chk("nest_err2", stk_err, EXP_ERR);

        // PC wrap from 0x1FF
        rom_fill();
        rom[1] = 12'hBFF;
        do_reset();
        steps(3);
        chk("wrap_pre", rom_addr, 9'h1FF);
        step();
        chk("wrap_addr", rom_addr, 9'h000);
        chk("wrap_ir", ir, 12'hCFF);

        // stall hold, stalled flush, reset with stall during GOTO bubble
        rom_fill();
        rom[6] = 12'hA40;
        do_reset();
        steps(4);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_pc", pc, 9'h004);
            chk("stall_ir", ir, 12'hC03);
            chk("stall_irv", ir_valid, 1'b1);
        end
        stall = 1'b0;
        steps(3);
        chk("sflush_ir", ir, 12'hA40);
        stall = 1'b1;
        steps(2);
        chk("sflush_pc", pc, 9'h007);
        chk("sflush_hold", ir, 12'hA40);
        stall = 1'b0;
        step();
        chk("sflush_tgt", pc, 9'h040);
        chk("sflush_irv", ir_valid, 1'b0);
        reset = 1'b1;
        stall = 1'b1;
        step();
        reset = 1'b0;
        stall = 1'b0;
        chk("mrst_pc", pc, 9'h000);
        chk("mrst_ir", ir, 12'h000);
        chk("mrst_irv", ir_valid, 1'b0);
        step();
        chk("mrst_run", ir, 12'hC00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
